// File: rtl/mult_div_if.sv
// Operand, control and result bundle between the MIPS controller and the
// iterative HI/LO multiply/divide unit.
interface mult_div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] Rs;
   logic [WIDTH-1:0] Rt;
   logic             hi_wen;
   logic             lo_wen;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, Rs, Rt, hi_wen, lo_wen,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, Rs, Rt, hi_wen, lo_wen,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO writes allowed
// CALC  | one shift-add / shift-subtract iteration per clock, WIDTH in all
// SIGN  | sign correction, atomic hi/lo update, done pulse follows
//
// Operation encoding: op[1] selects divide, op[0] selects unsigned.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   mult_div_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] SIGN = 2'd2;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

   logic [1:0]         state;
   logic [CW-1:0]      iter_cnt;
   logic [1:0]         op_q;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   rs_q;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;
   logic               dbz_q;

   // launch-side operand conditioning
   logic               in_signed;
   logic               in_neg_a;
   logic               in_neg_b;
   logic [WIDTH-1:0]   in_mag_a;
   logic [WIDTH-1:0]   in_mag_b;

   // iteration datapath
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] acc_next;

   // result shaping
   logic               is_div;
   logic               is_signed;
   logic               neg_result;
   logic               neg_rem;
   logic               b_zero;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quo_raw;
   logic [WIDTH-1:0]   rem_raw;
   logic [WIDTH-1:0]   quo_signed;
   logic [WIDTH-1:0]   rem_signed;
   logic [WIDTH-1:0]   hi_res;
   logic [WIDTH-1:0]   lo_res;

   // Signed ops work on magnitudes; the signs are reapplied in SIGN.
   always_comb begin
      in_signed = ~bus.op[0];
      in_neg_a  = in_signed & bus.Rs[WIDTH-1];
      in_neg_b  = in_signed & bus.Rt[WIDTH-1];
      in_mag_a  = in_neg_a ? ({WIDTH{1'b0}} - bus.Rs) : bus.Rs;
      in_mag_b  = in_neg_b ? ({WIDTH{1'b0}} - bus.Rt) : bus.Rt;
   end

   // One iteration of either algorithm over the shared accumulator.
   // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
   // Divide:   acc = {partial remainder, remaining dividend / quotient bits},
   //           shift left, quotient bit enters at the bottom.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc[WIDTH-1:1]};

      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, mag_b});
      // The partial remainder stays below the divisor, so the difference
      // always fits in WIDTH bits whenever it is taken.
      div_diff  = div_shift[WIDTH-1:0] - mag_b;
      div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
      div_next  = {div_rem, acc[WIDTH-2:0], div_ge};

      acc_next  = op_q[1] ? div_next : mul_next;
   end

   // Final sign correction and divide-by-zero substitution.
   always_comb begin
      is_div      = op_q[1];
      is_signed   = ~op_q[0];
      neg_result  = is_signed & (sign_a ^ sign_b);
      neg_rem     = is_signed & sign_a;
      b_zero      = (mag_b == {WIDTH{1'b0}});
      prod_signed = neg_result ? ({(2*WIDTH){1'b0}} - acc) : acc;
      quo_raw     = acc[WIDTH-1:0];
      rem_raw     = acc[2*WIDTH-1:WIDTH];
      quo_signed  = neg_result ? ({WIDTH{1'b0}} - quo_raw) : quo_raw;
      rem_signed  = neg_rem ? ({WIDTH{1'b0}} - rem_raw) : rem_raw;

      hi_res = prod_signed[2*WIDTH-1:WIDTH];
      lo_res = prod_signed[WIDTH-1:0];
      if (is_div) begin
         if (b_zero) begin
            hi_res = rs_q;
            lo_res = {WIDTH{1'b1}};
         end else begin
            hi_res = rem_signed;
            lo_res = quo_signed;
         end
      end
   end

   // Sequencer, iteration register and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         iter_cnt <= '0;
         op_q     <= 2'b00;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         mag_a    <= '0;
         mag_b    <= '0;
         rs_q     <= '0;
         acc      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q     <= bus.op;
                  sign_a   <= in_neg_a;
                  sign_b   <= in_neg_b;
                  mag_a    <= in_mag_a;
                  mag_b    <= in_mag_b;
                  rs_q     <= bus.Rs;
                  iter_cnt <= ITER_LAST;
                  // Divide shifts the dividend out of the low half; multiply
                  // shifts the multiplier out of it.
                  acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? in_mag_a : in_mag_b)};
                  state    <= CALC;
               end else begin
                  if (bus.hi_wen) hi_q <= bus.Rs;
                  if (bus.lo_wen) lo_q <= bus.Rs;
               end
            end
            CALC: begin
               acc <= acc_next;
               if (iter_cnt == '0) begin
                  state <= SIGN;
               end else begin
                  iter_cnt <= iter_cnt - 1'b1;
               end
            end
            SIGN: begin
               hi_q   <= hi_res;
               lo_q   <= lo_res;
               done_q <= 1'b1;
               dbz_q  <= is_div & b_zero;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = (state != IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;

endmodule
